// File: rtl/switch_debounce_events.sv
// Push-button conditioning: two-flop synchroniser, per-switch debounce and
// one-cycle press / release / long-press pulses. Every output is a flop.
module switch_debounce_events #(
  parameter int NUM_SWITCHES      = 4,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch_Level,
  output logic [NUM_SWITCHES-1:0] o_Press_Pulse,
  output logic [NUM_SWITCHES-1:0] o_Release_Pulse,
  output logic [NUM_SWITCHES-1:0] o_Long_Press_Pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [NUM_SWITCHES-1:0]         sync1_q, sync1_d;
  logic [NUM_SWITCHES-1:0]         sync2_q, sync2_d;
  logic [NUM_SWITCHES-1:0]         level_q, level_d;
  logic [NUM_SWITCHES-1:0]         press_q, press_d;
  logic [NUM_SWITCHES-1:0]         release_q, release_d;
  logic [NUM_SWITCHES-1:0]         long_q, long_d;
  logic [NUM_SWITCHES-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_SWITCHES-1:0][HW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    sync1_d    = i_Switch;
    sync2_d    = sync1_q;
    level_d    = level_q;
    press_d    = '0;
    release_d  = '0;
    long_d     = '0;
    deb_cnt_d  = '0;
    hold_cnt_d = '0;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      // A single matching sample leaves the counter at its cleared default.
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
      // Counting only while the level stays high keeps long-press and
      // release from ever landing in the same cycle.
      if (level_q[i] && level_d[i]) begin
        if (hold_cnt_q[i] != HOLD_MAX) begin
          hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
          long_d[i]     = (hold_cnt_q[i] == HOLD_MAX - HW'(1));
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign o_Switch_Level     = level_q;
  assign o_Press_Pulse      = press_q;
  assign o_Release_Pulse    = release_q;
  assign o_Long_Press_Pulse = long_q;

endmodule

// File: tb/tb_switch_debounce_events.sv
// Bench for switch_debounce_events: directed scenarios plus random bouncing,
// each checked against a cycle-level reference model and fixed latencies.
module tb_switch_debounce_events;
  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] lvl, prs, rel, lng;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_debounce_events #(
    .NUM_SWITCHES(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
    .o_Switch_Level(lvl), .o_Press_Pulse(prs),
    .o_Release_Pulse(rel), .o_Long_Press_Pulse(lng)
  );

  // Reference model: a level flips once the twice-delayed input has
  // disagreed with it for D edges in a row; long-press is the edge that is
  // exactly L edges after the press while the level is still high.
  logic [N-1:0] m_d1, m_d2, m_lvl, exp_press, exp_rel, exp_long;
  int           m_run [N];
  int           m_pedge [N];
  int           cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0;
      exp_press = '0; exp_rel = '0; exp_long = '0;
      cyc = 0;
      for (int c = 0; c < N; c++) begin
        m_run[c]   = 0;
        m_pedge[c] = -1000000;
      end
    end else begin
      cyc++;
      exp_press = '0; exp_rel = '0; exp_long = '0;
      for (int c = 0; c < N; c++) begin
        if (m_d2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = ~m_lvl[c];
            m_run[c] = 0;
            if (m_lvl[c]) begin
              exp_press[c] = 1'b1;
              m_pedge[c]   = cyc;
            end else begin
              exp_rel[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_lvl[c] && (cyc - m_pedge[c] == L)) exp_long[c] = 1'b1;
      end
      m_d2 = m_d1;
      m_d1 = sw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = '0;
    repeat (3) tick();
    total++;
    if ({lvl, prs, rel, lng} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0000", {lvl, prs, rel, lng});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
    end
  endtask

  task automatic test_clean_press();
    int press_k = -1, long_k = -1, rel_k = -1, np = 0, nl = 0, nr = 0;
    sw[0] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL clean_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (prs[0]) begin np++; if (press_k < 0) press_k = k; end
      if (lng[0]) begin nl++; if (long_k < 0) long_k = k; end
      if (rel[0]) begin nr++; if (rel_k < 0) rel_k = k; end
      if (k == 30) sw[0] = 1'b0;
    end
    total++;
    if (press_k != 6 || np != 1) begin
      bad++;
      $display("FAIL clean_press: got cycle %0d count %0d want cycle 6 count 1", press_k, np);
    end
    total++;
    if (long_k != 26 || nl != 1) begin
      bad++;
      $display("FAIL clean_long: got cycle %0d count %0d want cycle 26 count 1", long_k, nl);
    end
    total++;
    if (rel_k != 36 || nr != 1) begin
      bad++;
      $display("FAIL clean_release: got cycle %0d count %0d want cycle 36 count 1", rel_k, nr);
    end
  endtask

  task automatic test_bounce();
    int press_k = -1, np = 0, early = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 8)       sw[1] = (((k - 1) / 2) % 2 == 0);
      else if (k <= 20) sw[1] = 1'b1;
      else              sw[1] = 1'b0;
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL bounce_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (k < 14 && (prs[1] || rel[1] || lng[1] || lvl[1])) early++;
      if (prs[1]) begin np++; if (press_k < 0) press_k = k; end
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL bounce_quiet: got %0d active cycles want 0", early);
    end
    total++;
    if (press_k != 14 || np != 1) begin
      bad++;
      $display("FAIL bounce_press: got cycle %0d count %0d want cycle 14 count 1", press_k, np);
    end
  endtask

  task automatic test_short_press();
    int np = 0, nr = 0, nl = 0;
    for (int k = 1; k <= 30; k++) begin
      sw[2] = (k <= 10);
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL short_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (prs[2]) np++;
      if (rel[2]) nr++;
      if (lng[2]) nl++;
    end
    total++;
    if (np != 1 || nr != 1 || nl != 0) begin
      bad++;
      $display("FAIL short_counts: got press %0d release %0d long %0d want 1 1 0", np, nr, nl);
    end
  endtask

  task automatic test_simultaneous();
    int nz = 0;
    logic [N-1:0] at6 = '0;
    for (int k = 1; k <= 25; k++) begin
      sw = (k <= 12) ? '1 : '0;
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL simul_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (k == 6) at6 = prs;
      if (prs != '0) nz++;
    end
    total++;
    if (at6 !== 4'b1111 || nz != 1) begin
      bad++;
      $display("FAIL simul_press: got %b in %0d cycles want 1111 in 1 cycle", at6, nz);
    end
  endtask

  task automatic test_reset_mid();
    int press_k = -1, long_k = -1;
    sw[3] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL rstmid_pre cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({lvl, prs, rel, lng} !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_async: got %h want 0000", {lvl, prs, rel, lng});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL rstmid_post cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (prs[3] && press_k < 0) press_k = k;
      if (lng[3] && long_k < 0) long_k = k;
    end
    total++;
    if (press_k != 6 || long_k != 26) begin
      bad++;
      $display("FAIL rstmid_events: got press %0d long %0d want 6 26", press_k, long_k);
    end
    sw[3] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_long_hold();
    int nl = 0, long_k = -1, drops = 0;
    for (int k = 1; k <= 115; k++) begin
      sw[0] = (k <= 100);
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL hold_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
      if (lng[0]) begin nl++; if (long_k < 0) long_k = k; end
      if (k >= 6 && k <= 105 && !lvl[0]) drops++;
    end
    total++;
    if (nl != 1 || long_k != 26) begin
      bad++;
      $display("FAIL hold_long: got count %0d cycle %0d want 1 at 26", nl, long_k);
    end
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL hold_level: got %0d low cycles want 0", drops);
    end
  endtask

  task automatic test_random();
    int run_left [N];
    int rst_at = $urandom_range(200, 500);
    for (int c = 0; c < N; c++) run_left[c] = $urandom_range(1, 8);
    for (int k = 1; k <= 800; k++) begin
      for (int c = 0; c < N; c++) begin
        run_left[c]--;
        if (run_left[c] <= 0) begin
          sw[c]       = ~sw[c];
          run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
        end
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
      total++;
      if ({lvl, prs, rel, lng} !== {m_lvl, exp_press, exp_rel, exp_long}) begin
        bad++;
        $display("FAIL random_model cyc=%0d: got %h want %h", cyc, {lvl, prs, rel, lng},
                 {m_lvl, exp_press, exp_rel, exp_long});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_press();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
